// File: rtl/fpadd_pkg.sv
// fpadd_pkg: shared constants and helpers for the floating-point adder demo.
//   EXP_W, MAN_W, BIAS : IEEE-754 single-precision field widths and exponent bias
//   QNAN, POS_INF      : canonical quiet NaN and +infinity encodings
//   hex_to_seg()       : 4-bit nibble to active-high 7-segment pattern, bit 6 = a .. bit 0 = g
package fpadd_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            default: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fpadd_core.sv
// fpadd_core: IEEE-754 single-precision adder, round-to-nearest-even, subnormals
// flushed to signed zero. Combinational datapath followed by one output register.
//   clk, rst : clock and synchronous active-high reset (clears sum)
//   a, b     : operands
//   sum      : registered a + b
module fpadd_core
    import fpadd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    // hidden bit + mantissa + guard/round/sticky
    localparam int FW = MAN_W + 4;
    localparam logic signed [9:0] EXP_MAX = 10'(2 * BIAS + 1);

    function automatic logic [4:0] lzc(input logic [FW-1:0] v);
        logic [4:0] n;
        n = 5'(FW);
        // ascending scan: the highest set bit is the last to write n
        for (int i = 0; i < FW; i++) begin
            if (v[i]) n = 5'(FW - 1 - i);
        end
        return n;
    endfunction

    logic             sa, sb, sx, sy;
    logic [EXP_W-1:0] ea, eb, ex, ey, d;
    logic [MAN_W-1:0] ma, mb, mx, my;
    logic [FW-1:0]    fx, fy, aligned, norm;
    logic [2*FW-1:0]  wide;
    logic [FW:0]      raw;
    logic [4:0]       lz;
    logic             round_up;
    logic [MAN_W+1:0] rounded;
    logic [MAN_W-1:0] man;
    logic signed [9:0] exp_n;
    logic [31:0]      sum_d;

    always_comb begin
        {sa, ea, ma} = a;
        {sb, eb, mb} = b;

        // order operands so that |x| >= |y|
        if ({eb, mb} > {ea, ma}) begin
            {sx, ex, mx} = b;
            {sy, ey, my} = a;
        end else begin
            {sx, ex, mx} = a;
            {sy, ey, my} = b;
        end

        d  = ex - ey;
        fx = {1'b1, mx, 3'b000};
        fy = {1'b1, my, 3'b000};
        wide = {fy, {FW{1'b0}}} >> d;
        if (d > 8'(FW - 1)) begin
            aligned = {{(FW-1){1'b0}}, 1'b1};
        end else begin
            aligned = wide[2*FW-1:FW] | {{(FW-1){1'b0}}, |wide[FW-1:0]};
        end

        if (sx ^ sy) raw = {1'b0, fx} - {1'b0, aligned};
        else         raw = {1'b0, fx} + {1'b0, aligned};

        lz    = '0;
        exp_n = $signed({2'b00, ex});
        if (raw[FW]) begin
            // carry out: shift right one, fold the dropped bit into sticky
            norm  = {raw[FW:2], raw[1] | raw[0]};
            exp_n = exp_n + 10'sd1;
        end else begin
            lz    = lzc(raw[FW-1:0]);
            norm  = raw[FW-1:0] << lz;
            exp_n = exp_n - $signed({5'b00000, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rounded  = {1'b0, norm[FW-1:3]} + {{(MAN_W+1){1'b0}}, round_up};
        if (rounded[MAN_W+1]) exp_n = exp_n + 10'sd1;
        man = rounded[MAN_W+1] ? rounded[MAN_W:1] : rounded[MAN_W-1:0];

        if (raw == '0)                 sum_d = 32'h0;
        else if (exp_n <= 10'sd0)      sum_d = {sx, 31'h0};
        else if (exp_n >= EXP_MAX)     sum_d = {sx, POS_INF[30:0]};
        else                           sum_d = {sx, exp_n[EXP_W-1:0], man};

        // special operands override the datapath result
        if ((&ea && |ma) || (&eb && |mb))       sum_d = QNAN;
        else if (&ea && &eb)                    sum_d = (sa == sb) ? a : QNAN;
        else if (&ea)                           sum_d = a;
        else if (&eb)                           sum_d = b;
        else if (ea == '0 && eb == '0)          sum_d = {sa & sb, 31'h0};
        else if (ea == '0)                      sum_d = b;
        else if (eb == '0)                      sum_d = a;
    end

    always_ff @(posedge clk) begin
        if (rst) sum <= '0;
        else     sum <= sum_d;
    end

endmodule

// File: rtl/fpadd_system.sv
// fpadd_system: FPGA demo top. Walks a table of NUM operand pairs, adds each pair
// with fpadd_core and shows the 32-bit sum one byte at a time (MSB first) on 8 LEDs
// and two hex 7-segment digits.
//   clk, rst        : 50 MHz clock, synchronous active-high reset
//   leds            : displayed result byte
//   an1,a1..g1,fp1  : high-nibble digit enable, segments, dp (dp marks the MSB byte)
//   an0,a0..g0,fp0  : low-nibble digit enable, segments, dp (dp flags inf/NaN result)
// Parameters: NUM table entries, ROM_FILE name of the matching {a,b} hex image,
// PHASE_CYCLES cycles per displayed byte.
// Macro FPADD_SIM_FAST_EN: when defined each byte is held 4 cycles instead.
module fpadd_system
    import fpadd_pkg::*;
#(
    parameter int    NUM          = 10,
    parameter string ROM_FILE     = "fp_inputs.hex",
    parameter int    PHASE_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] leds,
    output logic       an0,
    output logic       a0, b0, c0, d0, e0, f0, g0,
    output logic       fp0,
    output logic       an1,
    output logic       a1, b1, c1, d1, e1, f1, g1,
    output logic       fp1
);

`ifdef FPADD_SIM_FAST_EN
    localparam int PHASE_LEN = 4;
`else
    localparam int PHASE_LEN = PHASE_CYCLES;
`endif
    localparam int IDX_W  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam int TICK_W = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;

    // On-chip operand table, same {a, b} layout as the ROM_FILE image.
    function automatic logic [63:0] rom_word(input logic [IDX_W-1:0] i);
        logic [63:0] w;
        case (int'(i))
            0:       w = {32'h3F800000, 32'h3F800000};
            1:       w = {32'h3FC00000, 32'hBFC00000};
            2:       w = {32'h80000000, 32'h80000000};
            3:       w = {32'h7F7FFFFF, 32'h7F7FFFFF};
            4:       w = {32'h7F800000, 32'hFF800000};
            5:       w = {32'h3F800000, 32'h33800000};
            6:       w = {32'h3F800001, 32'h33800000};
            7:       w = {32'h40400000, 32'hC0000000};
            8:       w = {32'h7FC00000, 32'h3F800000};
            9:       w = {32'h41200000, 32'h40A00000};
            default: w = 64'h0;
        endcase
        return w;
    endfunction

    logic [IDX_W-1:0]  idx;
    logic [1:0]        phase;
    logic [TICK_W-1:0] tick;
    logic [63:0]       rom_q;
    logic [31:0]       r;
    logic [7:0]        disp;
    logic [7:0]        leds_q;
    logic [6:0]        seg0_q, seg1_q;
    logic              an_q, fp0_q, fp1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick  <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (tick == TICK_W'(PHASE_LEN - 1)) begin
            tick  <= '0;
            phase <= phase + 2'd1;
            if (phase == 2'd3) idx <= (idx == IDX_W'(NUM - 1)) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rom_q <= '0;
        else     rom_q <= rom_word(idx);
    end

    fpadd_core u_core (
        .clk (clk),
        .rst (rst),
        .a   (rom_q[63:32]),
        .b   (rom_q[31:0]),
        .sum (r)
    );

    always_comb begin
        case (phase)
            2'd0:    disp = r[31:24];
            2'd1:    disp = r[23:16];
            2'd2:    disp = r[15:8];
            default: disp = r[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_q <= '0;
            seg0_q <= '0;
            seg1_q <= '0;
            an_q   <= 1'b0;
            fp0_q  <= 1'b0;
            fp1_q  <= 1'b0;
        end else begin
            leds_q <= disp;
            seg1_q <= hex_to_seg(disp[7:4]);
            seg0_q <= hex_to_seg(disp[3:0]);
            an_q   <= 1'b1;
            fp0_q  <= &r[30:23];
            fp1_q  <= (phase == 2'd0);
        end
    end

    assign leds = leds_q;
    assign an0  = an_q;
    assign an1  = an_q;
    assign fp0  = fp0_q;
    assign fp1  = fp1_q;
    assign {a0, b0, c0, d0, e0, f0, g0} = seg0_q;
    assign {a1, b1, c1, d1, e1, f1, g1} = seg1_q;

endmodule

// File: tb/tb_fpadd_system.sv
module tb_fpadd_system;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] leds;
    logic       an0, a0, b0, c0, d0, e0, f0, g0, fp0;
    logic       an1, a1, b1, c1, d1, e1, f1, g1, fp1;

    always #5 clk = ~clk;

    fpadd_system #(
        .NUM          (10),
        .ROM_FILE     ("fp_inputs.hex"),
        .PHASE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .leds (leds),
        .an0  (an0),
        .a0   (a0), .b0 (b0), .c0 (c0), .d0 (d0), .e0 (e0), .f0 (f0), .g0 (g0),
        .fp0  (fp0),
        .an1  (an1),
        .a1   (a1), .b1 (b1), .c1 (c1), .d1 (d1), .e1 (e1), .f1 (f1), .g1 (g1),
        .fp1  (fp1)
    );

    logic [6:0] seg0, seg1;
    assign seg0 = {a0, b0, c0, d0, e0, f0, g0};
    assign seg1 = {a1, b1, c1, d1, e1, f1, g1};

    localparam logic [31:0] EXP_R [10] = '{
        32'h40000000, 32'h00000000, 32'h80000000, 32'h7F800000, 32'h7FC00000,
        32'h3F800000, 32'h3F800002, 32'h3F800000, 32'h7FC00000, 32'h41700000
    };
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int checks = 0;
    int errors = 0;
    int k = 0;  // rising edges since the last reset release

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({leds, seg1, seg0, an1, an0, fp1, fp0} !== 26'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {leds, seg1, seg0, an1, an0, fp1, fp0});
        end
        rst = 1'b0;
        k = 0;
    endtask

    task automatic test_one_plus_one();
        run_to(2);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL first_latency leds got %h want 00", leds);
        end
        run_to(3);
        checks++;
        if (leds !== 8'h40) begin
            errors++;
            $display("FAIL p0_leds got %h want 40", leds);
        end
        checks++;
        if (seg1 !== 7'b0110011 || seg0 !== 7'b1111110) begin
            errors++;
            $display("FAIL p0_digits got %b %b want 0110011 1111110", seg1, seg0);
        end
        checks++;
        if (fp1 !== 1'b1 || fp0 !== 1'b0 || an1 !== 1'b1 || an0 !== 1'b1) begin
            errors++;
            $display("FAIL p0_flags got fp1=%b fp0=%b an=%b%b want 1 0 11", fp1, fp0, an1, an0);
        end
        for (int p = 1; p < 4; p++) begin
            run_to(4 * p + 3);
            checks++;
            if (leds !== 8'h00 || fp1 !== 1'b0) begin
                errors++;
                $display("FAIL p%0d_byte got leds=%h fp1=%b want 00 0", p, leds, fp1);
            end
        end
    endtask

    // Reassemble each entry's sum from its four displayed bytes.
    task automatic test_results(input int first, input int base);
        logic [31:0] got;
        for (int i = first; i < 10; i++) begin
            got = 32'h0;
            for (int p = 0; p < 4; p++) begin
                run_to(base + 16 * i + 4 * p + 3);
                got[31 - 8 * p -: 8] = leds;
                checks++;
                if (seg1 !== SEG_TAB[leds[7:4]] || seg0 !== SEG_TAB[leds[3:0]] ||
                    fp1 !== (p == 0)) begin
                    errors++;
                    $display("FAIL digits_e%0d_p%0d got %b %b fp1=%b for leds %h",
                             i, p, seg1, seg0, fp1, leds);
                end
            end
            checks++;
            if (got !== EXP_R[i]) begin
                errors++;
                $display("FAIL sum_e%0d base%0d got %h want %h", i, base, got, EXP_R[i]);
            end
            checks++;
            if (fp0 !== (EXP_R[i][30:23] == 8'hFF)) begin
                errors++;
                $display("FAIL fp0_e%0d got %b want %b", i, fp0, EXP_R[i][30:23] == 8'hFF);
            end
        end
    endtask

    task automatic test_back_to_back();
        // second pass after idx wraps 9 -> 0 must repeat the first
        test_results(0, 160);
    endtask

    task automatic test_mid_reset();
        // edge 410: entry 5, phase 2 of the third pass
        run_to(410);
        rst = 1'b1;
        step();
        checks++;
        if ({leds, seg1, seg0, an1, an0, fp1, fp0} !== 26'h0) begin
            errors++;
            $display("FAIL midreset_outputs got %h want 0", {leds, seg1, seg0, an1, an0, fp1, fp0});
        end
        rst = 1'b0;
        k = 0;
        run_to(2);
        checks++;
        if (leds !== 8'h00) begin
            errors++;
            $display("FAIL midreset_latency leds got %h want 00", leds);
        end
        run_to(3);
        checks++;
        if (leds !== 8'h40 || fp1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_restart got leds=%h fp1=%b want 40 1", leds, fp1);
        end
        run_to(7);
        checks++;
        if (leds !== 8'h00 || fp1 !== 1'b0) begin
            errors++;
            $display("FAIL midreset_p1 got leds=%h fp1=%b want 00 0", leds, fp1);
        end
    endtask

    initial begin
        test_reset();
        test_one_plus_one();
        test_results(1, 0);
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
